zero_indices_collect: RTL

//  Receive end of the zero-index stream: rebuilds a W-bit vector from a framed

---
 rtl/zero_indices_collect_pkg.sv | 18 +
 rtl/zero_indices_collect_if.sv | 29 ++
 rtl/zero_indices_collect.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/zero_indices_collect_pkg.sv
// Shared types for the zero-index producer/consumer pair: default index and
// count widths plus the collector state encoding.
package zero_indices_pkg;

  localparam int unsigned ZI_W  = 128;
  localparam int unsigned ZI_IW = $clog2(ZI_W);
  localparam int unsigned ZI_CW = $clog2(ZI_W + 1);

  typedef logic [ZI_IW-1:0] index_t;
  typedef logic [ZI_CW-1:0] count_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_e;

endpackage

// File: rtl/zero_indices_collect_if.sv
// Framed index stream in, rebuilt vector out over a valid/ready handshake.
interface zero_indices_collect_if #(
  parameter int unsigned W  = 128,
  parameter int unsigned IW = $clog2(W),
  parameter int unsigned CW = $clog2(W + 1)
);

  logic          in_start;
  logic          in_valid;
  logic [IW-1:0] in_index;
  logic          in_done;
  logic          in_busy_r;
  logic          out_valid_r;
  logic          out_ready;
  logic [W-1:0]  out_vector_r;
  logic [CW-1:0] out_count_r;
  logic          out_err_r;

  modport master (
    output in_start, in_valid, in_index, in_done, out_ready,
    input  in_busy_r, out_valid_r, out_vector_r, out_count_r, out_err_r
  );

  modport slave (
    input  in_start, in_valid, in_index, in_done, out_ready,
    output in_busy_r, out_valid_r, out_vector_r, out_count_r, out_err_r
  );

endinterface

// File: rtl/zero_indices_collect.sv
// Rebuilds a W-bit vector from an ascending stream of zero-bit indices and
// presents it, with the zero count and an ordering/range error flag.
module zero_indices_collect
  import zero_indices_pkg::*;
#(
    parameter int unsigned W  = 128,
    parameter int unsigned IW = $clog2(W),
    parameter int unsigned CW = $clog2(W + 1)
) (
    input logic clk,
    input logic rst,
    zero_indices_collect_if.slave bus
);

    localparam logic [IW:0] W_LIM = (IW + 1)'(W);

    function automatic logic [W-1:0] clr_mask(input logic [IW-1:0] idx);
        logic [W-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < W; i++) begin
            m[i] = (idx == i[IW-1:0]);
        end
        return m;
    endfunction

    state_e        state_q, state_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic [IW-1:0] prev_q, prev_d;
    logic          prev_valid_q, prev_valid_d;
    logic          out_valid_q, out_valid_d;
    logic [W-1:0]  out_vector_q, out_vector_d;
    logic [CW-1:0] out_count_q, out_count_d;
    logic          out_err_q, out_err_d;
    logic          busy_q, busy_d;

    logic          accept;
    logic          idx_ok;
    logic [W-1:0]  acc_app;
    logic [CW-1:0] cnt_app;
    logic          err_app;

    assign accept = out_valid_q && bus.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            acc_q        <= '1;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_vector_q <= '1;
            out_count_q  <= '0;
            out_err_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
            out_valid_q  <= out_valid_d;
            out_vector_q <= out_vector_d;
            out_count_q  <= out_count_d;
            out_err_q    <= out_err_d;
            busy_q       <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_start) state_d = COLLECT;
            COLLECT: if (!bus.in_start && bus.in_done) state_d = HOLD;
            HOLD:    if (accept) state_d = bus.in_start ? COLLECT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The index is applied first so a same-cycle in_done captures it.
    always_comb begin
        idx_ok  = ({1'b0, bus.in_index} < W_LIM)
                  && (!prev_valid_q || bus.in_index > prev_q);
        acc_app = acc_q;
        cnt_app = cnt_q;
        err_app = err_q;
        if (bus.in_valid) begin
            if (idx_ok) begin
                acc_app = acc_q & ~clr_mask(bus.in_index);
                cnt_app = cnt_q + CW'(1);
            end else begin
                err_app = 1'b1;
            end
        end
    end

    always_comb begin
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        prev_d       = prev_q;
        prev_valid_d = prev_valid_q;
        out_valid_d  = out_valid_q;
        out_vector_d = out_vector_q;
        out_count_d  = out_count_q;
        out_err_d    = out_err_q;

        if (bus.in_start && (state_q != HOLD || accept)) begin
            acc_d        = '1;
            cnt_d        = '0;
            err_d        = 1'b0;
            prev_valid_d = 1'b0;
        end else if (state_q == COLLECT) begin
            acc_d = acc_app;
            cnt_d = cnt_app;
            err_d = err_app;
            if (bus.in_valid && idx_ok) begin
                prev_d       = bus.in_index;
                prev_valid_d = 1'b1;
            end
            if (bus.in_done) begin
                out_valid_d  = 1'b1;
                out_vector_d = acc_app;
                out_count_d  = cnt_app;
                out_err_d    = err_app;
            end
        end

        if (state_q == HOLD && accept) out_valid_d = 1'b0;

        busy_d = (state_d != IDLE);
    end

    assign bus.in_busy_r    = busy_q;
    assign bus.out_valid_r  = out_valid_q;
    assign bus.out_vector_r = out_vector_q;
    assign bus.out_count_r  = out_count_q;
    assign bus.out_err_r    = out_err_q;

endmodule
